mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 80 ++++++++
 tb/tb_mul_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add unsigned multiplier, one step per clock
module mul_seq #(
   parameter int M = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [M-1:0]   A,
   input  logic [M-1:0]   B,
   output logic [2*M-1:0] P,
   output logic [M-1:0]   R,
   output logic           ovf,
   output logic           busy,
   output logic           done
);
   localparam int CW = $clog2(M + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t         state_q, state_d;
   logic [M-1:0]   a_q, a_d, b_q, b_d;
   logic [2*M-1:0] acc_q, acc_d, p_q, p_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           busy_q, busy_d, done_q, done_d;
   logic [M:0]     sum;
   // next-state, datapath step and registered output values
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      sum     = {1'b0, acc_q[2*M-1:M]} + (b_q[0] ? {1'b0, a_q} : '0);
      if (state_q != RUN && start) begin
         state_d = RUN;
         a_d     = A;
         b_d     = B;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         acc_d = {sum, acc_q[M-1:1]};
         b_d   = b_q >> 1;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(M - 1)) begin
            state_d = DONE;
            p_d     = {sum, acc_q[M-1:1]};
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
      busy_d = state_d == RUN;
      done_d = state_d == DONE;
   end
   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign P    = p_q;
   assign R    = p_q[M-1:0];
   assign ovf  = |p_q[2*M-1:M];
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: table, corner-sequence and random checks of mul_seq against a*b
module tb_mul_seq;
   localparam int M = 4;
   logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [M-1:0] A = '0, B = '0;
   logic [7:0]   P;
   logic [M-1:0] R;
   logic         ovf, busy, done;
   int           errors = 0, checks = 0;
   logic [7:0]   last_p = '0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
      logic       ovf;
   } vec_t;
   vec_t vec[8];

   mul_seq #(.M(M)) dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
                         .P(P), .R(R), .ovf(ovf), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input string nm);
      logic [7:0] exp;
      logic [3:0] exp_r;
      int lat, bc;
      bit held;
      exp   = 8'(a) * 8'(b);
      exp_r = exp[3:0];
      @(negedge clk);
      start = 1'b1; A = a; B = b;
      @(negedge clk);
      start = 1'b0; A = 4'($urandom); B = 4'($urandom);
      lat = 0; bc = 0; held = 1'b1;
      while (!done && lat < 20) begin
         if (busy) bc++;
         if (P !== last_p) held = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, lat, M);
      chk({nm, "_busy_cycles"}, bc, M);
      chk({nm, "_p_held_in_run"}, 32'(held), 1);
      chk({nm, "_p"}, P, exp);
      chk({nm, "_r"}, R, exp_r);
      chk({nm, "_ovf"}, ovf, 32'(exp[7:4] != 0));
      chk({nm, "_busy_in_done"}, busy, 0);
      last_p = exp;
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, done, 0);
      chk({nm, "_p_after"}, P, exp);
   endtask

   initial begin
      vec[0] = '{4'd3,  4'd5,  8'h0F, 1'b0};
      vec[1] = '{4'd15, 4'd15, 8'hE1, 1'b1};
      vec[2] = '{4'd0,  4'd9,  8'h00, 1'b0};
      vec[3] = '{4'd9,  4'd1,  8'h09, 1'b0};
      vec[4] = '{4'd15, 4'd1,  8'h0F, 1'b0};
      vec[5] = '{4'd1,  4'd15, 8'h0F, 1'b0};
      vec[6] = '{4'd8,  4'd8,  8'h40, 1'b1};
      vec[7] = '{4'd12, 4'd0,  8'h00, 1'b0};

      // reset, with start asserted to confirm reset priority
      @(negedge clk);
      rst = 1'b1; start = 1'b1; A = 4'd7; B = 4'd7;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("reset_p", P, 0);
      chk("reset_r", R, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);

      // table vectors
      for (int i = 0; i < 8; i++) begin
         logic [3:0] er;
         do_op(vec[i].a, vec[i].b, $sformatf("vec%0d", i));
         er = vec[i].p[3:0];
         chk($sformatf("vec%0d_table_p", i), P, vec[i].p);
         chk($sformatf("vec%0d_table_r", i), R, er);
         chk($sformatf("vec%0d_table_ovf", i), ovf, vec[i].ovf);
      end

      // 15*15 result must hold through 10 idle cycles
      do_op(4'd15, 4'd15, "hold");
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_idle_p", P, 8'hE1);
         chk("hold_idle_done", done, 0);
      end

      // start pulsed during RUN is ignored
      begin
         int dc, di, bc;
         @(negedge clk);
         start = 1'b1; A = 4'd6; B = 4'd7;
         dc = 0; di = -1; bc = 0;
         for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            start = (k == 1);
            if (k == 1) begin A = 4'd2; B = 4'd2; end
            if (done) begin dc++; di = k; end
            if (busy) bc++;
         end
         chk("ignore_done_count", dc, 1);
         chk("ignore_done_idx", di, M);
         chk("ignore_busy_cycles", bc, M);
         chk("ignore_p", P, 8'h2A);
         last_p = 8'h2A;
      end

      // reset in mid-RUN aborts with no done pulse
      begin
         int dc, bc;
         @(negedge clk);
         start = 1'b1; A = 4'd5; B = 4'd5;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("abort_p", P, 0);
         chk("abort_busy", busy, 0);
         dc = 0; bc = 0;
         for (int k = 0; k < 8; k++) begin
            if (done) dc++;
            if (busy) bc++;
            @(negedge clk);
         end
         chk("abort_no_done", dc, 0);
         chk("abort_no_busy", bc, 0);
         last_p = '0;
      end

      // start held high: back-to-back operations
      begin
         int di[$];
         logic [7:0] dp[$];
         @(negedge clk);
         start = 1'b1; A = 4'd2; B = 4'd3;
         for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) begin A = 4'd4; B = 4'd4; end
            if (done) begin di.push_back(k); dp.push_back(P); end
            if (k == 9) start = 1'b0;
         end
         chk("b2b_done_count", di.size(), 2);
         if (di.size() == 2) begin
            chk("b2b_first_idx", di[0], M);
            chk("b2b_spacing", di[1] - di[0], M + 1);
            chk("b2b_first_p", dp[0], 8'h06);
            chk("b2b_second_p", dp[1], 8'h10);
         end
         chk("b2b_final_p", P, 8'h10);
         chk("b2b_idle_busy", busy, 0);
         last_p = 8'h10;
      end

      // randomized operations against a*b
      for (int n = 0; n < 40; n++) begin
         int gap;
         do_op(4'($urandom), 4'($urandom), $sformatf("rnd%0d", n));
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
